// File: rtl/histogram_stream_engine_if.sv
// Pixel-in / result-out stream bundle for the histogram engine.
// The engine sits on the slave modport; the pixel source and the result sink use master.
interface histogram_stream_engine_if #(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned COUNT_W = 24
) ();

  localparam int unsigned OUT_W = PIX_W + COUNT_W;

  logic             in_valid_i;
  logic [PIX_W-1:0] in_data_i;
  logic             in_ready_o;
  logic             out_valid_o;
  logic [OUT_W-1:0] out_data_o;
  logic             out_last_o;
  logic             out_ready_i;

  modport master (
    output in_valid_i,
    output in_data_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  out_data_o,
    input  out_last_o
  );

  modport slave (
    input  in_valid_i,
    input  in_data_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output out_data_o,
    output out_last_o
  );

endinterface

// File: rtl/histogram_stream_engine.sv
// Streaming histogram engine: clears 2^PIX_W bins, bins NUM_PIXELS pixels at one per
// cycle through a forwarded read-modify-write pipeline, then reads out {bin, count}
// words in plain or cumulative form.
module histogram_stream_engine #(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned COUNT_W    = 24,
  parameter int unsigned NUM_PIXELS = 76800
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic                            mode_i,
  histogram_stream_engine_if.slave        bus,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int unsigned NBINS  = 1 << PIX_W;
  localparam int unsigned OUT_W  = PIX_W + COUNT_W;
  localparam int unsigned PCNT_W = $clog2(NUM_PIXELS + 1);

  localparam logic [PIX_W:0]      LastBin  = (PIX_W + 1)'(NBINS - 1);
  localparam logic [PCNT_W-1:0]   LastPix  = PCNT_W'(NUM_PIXELS - 1);
  localparam logic [COUNT_W-1:0]  CountMax = '1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StAccum,
    StFlush,
    StReadout,
    StDone
  } state_e;

  state_e              state_q;
  logic                mode_q;
  logic [PIX_W:0]      bin_cnt_q;
  logic [PCNT_W-1:0]   pix_cnt_q;
  logic                flush_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [OUT_W-1:0]    out_data_q;
  logic                out_last_q;
  logic                busy_q;
  logic                done_q;
  logic [COUNT_W-1:0]  cum_q;

  // Update pipeline: s1 holds the accepted pixel, s2 holds its incremented count
  logic                s1_valid_q;
  logic [PIX_W-1:0]    s1_bin_q;
  logic                s2_valid_q;
  logic [PIX_W-1:0]    s2_bin_q;
  logic [COUNT_W-1:0]  s2_cnt_q;

  logic [COUNT_W-1:0]  mem_q [NBINS];

  logic                accept;
  logic [COUNT_W-1:0]  s1_fwd;
  logic [COUNT_W-1:0]  s1_inc;
  logic [PIX_W-1:0]    ro_addr;
  logic [COUNT_W-1:0]  ro_cnt;
  logic [COUNT_W-1:0]  cum_base;
  logic [COUNT_W:0]    sum_wide;
  logic [COUNT_W-1:0]  ro_sum;
  logic [COUNT_W-1:0]  ro_word_cnt;
  logic                mem_we;
  logic [PIX_W-1:0]    mem_waddr;
  logic [COUNT_W-1:0]  mem_wdata;

  assign accept = bus.in_valid_i & in_ready_q;

  // Bin read with forwarding from the write in flight, saturating increment and readout sum
  always_comb begin
    s1_fwd = mem_q[s1_bin_q];
    if (s2_valid_q && (s2_bin_q == s1_bin_q)) begin
      s1_fwd = s2_cnt_q;
    end
    s1_inc = (s1_fwd == CountMax) ? s1_fwd : s1_fwd + 1'b1;

    // The first readout word is loaded while the last update is still being written
    ro_addr = (state_q == StReadout) ? bin_cnt_q[PIX_W-1:0] : '0;
    ro_cnt  = mem_q[ro_addr];
    if (s2_valid_q && (s2_bin_q == ro_addr)) begin
      ro_cnt = s2_cnt_q;
    end
    cum_base    = (state_q == StReadout) ? cum_q : '0;
    sum_wide    = {1'b0, cum_base} + {1'b0, ro_cnt};
    ro_sum      = sum_wide[COUNT_W] ? CountMax : sum_wide[COUNT_W-1:0];
    ro_word_cnt = mode_q ? ro_sum : ro_cnt;

    mem_we    = (state_q == StClear) || s2_valid_q;
    mem_waddr = (state_q == StClear) ? bin_cnt_q[PIX_W-1:0] : s2_bin_q;
    mem_wdata = (state_q == StClear) ? '0 : s2_cnt_q;
  end

  // Bin RAM: single write port, no reset (cleared in CLEAR instead)
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read-modify-write pipeline registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_bin_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_bin_q   <= '0;
      s2_cnt_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_bin_q <= bus.in_data_i;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_bin_q <= s1_bin_q;
        s2_cnt_q <= s1_inc;
      end
    end
  end

  // Frame sequencing FSM with registered handshake and status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      bin_cnt_q   <= '0;
      pix_cnt_q   <= '0;
      flush_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cum_q       <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_q   <= StClear;
            mode_q    <= mode_i;
            bin_cnt_q <= '0;
            pix_cnt_q <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        StClear: begin
          bin_cnt_q <= bin_cnt_q + 1'b1;
          if (bin_cnt_q == LastBin) begin
            state_q    <= StAccum;
            in_ready_q <= 1'b1;
          end
        end
        StAccum: begin
          if (accept) begin
            if (pix_cnt_q == LastPix) begin
              state_q    <= StFlush;
              in_ready_q <= 1'b0;
              flush_q    <= 1'b0;
            end else begin
              pix_cnt_q <= pix_cnt_q + 1'b1;
            end
          end
        end
        StFlush: begin
          flush_q <= 1'b1;
          if (flush_q) begin
            state_q     <= StReadout;
            out_valid_q <= 1'b1;
            out_data_q  <= {{PIX_W{1'b0}}, ro_word_cnt};
            out_last_q  <= 1'b0;
            cum_q       <= ro_sum;
            bin_cnt_q   <= (PIX_W + 1)'(1);
          end
        end
        StReadout: begin
          if (out_valid_q && bus.out_ready_i) begin
            if (out_last_q) begin
              state_q     <= StDone;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              out_data_q <= {bin_cnt_q[PIX_W-1:0], ro_word_cnt};
              out_last_q <= (bin_cnt_q == LastBin);
              cum_q      <= ro_sum;
              bin_cnt_q  <= bin_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_last_o  = out_last_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_histogram_stream_engine.sv
// Bench for histogram_stream_engine: a reduced-frame 8-bit instance checked against a
// histogram model every cycle, plus a 4-bit saturating instance with literal expectations.
module tb_histogram_stream_engine;

  localparam int unsigned PW   = 8;
  localparam int unsigned CW   = 24;
  localparam int unsigned NP   = 768;
  localparam int unsigned NB   = 256;
  localparam int          MAXC = (1 << CW) - 1;
  localparam int unsigned PWB  = 4;
  localparam int unsigned CWB  = 4;
  localparam int unsigned NPB  = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, mode_a = 1'b0, busy_a, done_a;
  logic start_b = 1'b0, mode_b = 1'b0, busy_b, done_b;

  histogram_stream_engine_if #(.PIX_W(PW),  .COUNT_W(CW))  bus_a ();
  histogram_stream_engine_if #(.PIX_W(PWB), .COUNT_W(CWB)) bus_b ();

  histogram_stream_engine #(.PIX_W(PW), .COUNT_W(CW), .NUM_PIXELS(NP)) dut_a (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start_a),
    .mode_i  (mode_a),
    .bus     (bus_a),
    .busy_o  (busy_a),
    .done_o  (done_a)
  );

  histogram_stream_engine #(.PIX_W(PWB), .COUNT_W(CWB), .NUM_PIXELS(NPB)) dut_b (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start_b),
    .mode_i  (mode_b),
    .bus     (bus_b),
    .busy_o  (busy_b),
    .done_o  (done_b)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model state for instance A
  int          hist [NB];
  int          acc_cnt = 0;
  bit          frame_active = 1'b0;
  int          model_mode = 0;
  logic [31:0] exp_q [$];
  logic [31:0] got_word [NB];
  int          words_seen = 0;
  bit          hold_pend = 1'b0;
  logic [31:0] held = '0;
  bit          expect_done = 1'b0;
  bit          lat_armed = 1'b0;
  int          lat = 0;
  int          stall_pct = 0;

  task automatic model_start(input int m);
    for (int k = 0; k < NB; k++) hist[k] = 0;
    acc_cnt      = 0;
    frame_active = 1'b1;
    model_mode   = m;
    words_seen   = 0;
  endtask

  task automatic model_reset();
    frame_active = 1'b0;
    exp_q.delete();
    acc_cnt     = 0;
    lat_armed   = 1'b0;
    hold_pend   = 1'b0;
    expect_done = 1'b0;
  endtask

  // Expected readout: per-bin saturated counts, cumulative sum saturated again
  task automatic build_expected();
    int run;
    int c;
    logic [7:0]  kb;
    logic [23:0] v;
    run = 0;
    for (int k = 0; k < NB; k++) begin
      c   = (hist[k] > MAXC) ? MAXC : hist[k];
      run = run + c;
      if (run > MAXC) run = MAXC;
      kb = 8'(k);
      v  = (model_mode != 0) ? 24'(run) : 24'(c);
      exp_q.push_back({kb, v});
    end
  endtask

  // Sink-side back-pressure for instance A
  always @(posedge clk) begin
    #1;
    bus_a.out_ready_i = ($urandom_range(99) >= stall_pct);
  end

  // Per-cycle compare of instance A against the model
  always @(negedge clk) begin
    if (rst_n) begin
      // Accept edge is the posedge after this sample, so first valid shows at lat == 3
      if (lat_armed) begin
        lat++;
        if (bus_a.out_valid_o || lat > 3) begin
          check("first_valid_latency", 64'(lat), 64'd3);
          lat_armed = 1'b0;
        end
      end
      if (!frame_active) check("ready_outside_frame", 64'(bus_a.in_ready_o), 64'd0);
      if (bus_a.in_valid_i && bus_a.in_ready_o && frame_active) begin
        hist[bus_a.in_data_i]++;
        acc_cnt++;
        if (acc_cnt == NP) begin
          build_expected();
          frame_active = 1'b0;
          lat          = 0;
          lat_armed    = 1'b1;
        end
      end
      if (expect_done) begin
        check("done_after_last", 64'({done_a, busy_a, bus_a.out_valid_o}), 64'b100);
        expect_done = 1'b0;
      end
      if (hold_pend) begin
        check("hold_valid", 64'(bus_a.out_valid_o), 64'd1);
        check("hold_data", 64'(bus_a.out_data_o), 64'(held));
      end
      if (bus_a.out_valid_o) begin
        if (bus_a.out_ready_i) begin
          check("word_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            logic [31:0] w;
            w = exp_q.pop_front();
            check("word_data", 64'(bus_a.out_data_o), 64'(w));
            check("word_last", 64'(bus_a.out_last_o), 64'(w[31:24] == 8'hff));
            got_word[w[31:24]] = bus_a.out_data_o;
            words_seen++;
            if (w[31:24] == 8'hff) begin
              check("word_count", 64'(words_seen), 64'(NB));
              expect_done = 1'b1;
            end
          end
        end
        hold_pend = !bus_a.out_ready_i;
        held      = bus_a.out_data_o;
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  // pat: 0 const 5, 1 ramp, 2 A,A,B,A,B,B, 3 random; abort_after>0 resets mid-frame
  task automatic run_frame(input int m, input int pat, input int gap, input int stall,
                           input int abort_after, input int ignore_at);
    int          i;
    int          cyc;
    bit          acc;
    logic [7:0]  pa;
    logic [7:0]  pb;
    logic [7:0]  px;
    logic [5:0]  alt;
    alt       = 6'b110100;
    stall_pct = stall;
    pa = 8'($urandom_range(255));
    pb = pa + 8'($urandom_range(254)) + 8'd1;
    @(posedge clk); #1;
    start_a = 1'b1;
    mode_a  = m[0];
    model_start(m);
    @(posedge clk); #1;
    start_a = 1'b0;
    i   = 0;
    cyc = 0;
    while (i < NP && cyc < 20000) begin
      case (pat)
        0:       px = 8'h05;
        1:       px = 8'(i);
        2:       px = alt[i % 6] ? pb : pa;
        default: px = 8'($urandom_range(255));
      endcase
      bus_a.in_data_i  = px;
      bus_a.in_valid_i = ($urandom_range(99) >= gap);
      if (ignore_at > 0 && i == ignore_at) begin
        start_a = 1'b1;
        mode_a  = !m[0];
      end else begin
        start_a = 1'b0;
      end
      @(negedge clk);
      acc = bus_a.in_valid_i && bus_a.in_ready_o;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
      if (abort_after > 0 && i == abort_after) begin
        rst_n            = 1'b0;
        bus_a.in_valid_i = 1'b0;
        start_a          = 1'b0;
        #1;
        check("abort_outputs", 64'({bus_a.in_ready_o, bus_a.out_valid_o, bus_a.out_last_o,
                                    busy_a, done_a, bus_a.out_data_o}), 64'd0);
        model_reset();
        @(posedge clk); #3;
        rst_n = 1'b1;
        return;
      end
    end
    start_a = 1'b0;
    check("pixels_accepted", 64'(i), 64'(NP));
    // Junk pixels during readout must not be consumed
    bus_a.in_valid_i = 1'b1;
    bus_a.in_data_i  = 8'($urandom_range(255));
    cyc = 0;
    while (!done_a && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("frame_done", 64'(done_a), 64'd1);
    bus_a.in_valid_i = 1'b0;
  endtask

  // Instance B: all pixels = 3, readout collected with out_ready held high
  task automatic run_b(input int m);
    int          n;
    int          k;
    int          cyc;
    int          e;
    bit          acc;
    @(posedge clk); #1;
    start_b = 1'b1;
    mode_b  = m[0];
    @(posedge clk); #1;
    start_b = 1'b0;
    bus_b.in_valid_i = 1'b1;
    bus_b.in_data_i  = 4'd3;
    n   = 0;
    cyc = 0;
    while (n < NPB && cyc < 500) begin
      @(negedge clk);
      acc = bus_b.in_valid_i && bus_b.in_ready_o;
      @(posedge clk); #1;
      if (acc) n++;
      cyc++;
    end
    bus_b.in_valid_i = 1'b0;
    k   = 0;
    cyc = 0;
    while (k < 16 && cyc < 500) begin
      @(negedge clk);
      if (bus_b.out_valid_o && bus_b.out_ready_i) begin
        e = (m != 0) ? ((k >= 3) ? 15 : 0) : ((k == 3) ? 15 : 0);
        check("b_word", 64'(bus_b.out_data_o), 64'({4'(k), 4'(e)}));
        check("b_last", 64'(bus_b.out_last_o), 64'(k == 15));
        k++;
      end
      cyc++;
    end
    check("b_words", 64'(k), 64'd16);
    @(negedge clk);
    check("b_done", 64'({done_b, busy_b}), 64'b10);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.in_valid_i = 1'b0;
    bus_a.in_data_i  = '0;
    bus_b.in_valid_i = 1'b0;
    bus_b.in_data_i  = '0;
    bus_b.out_ready_i = 1'b1;
    #2;
    check("reset_outputs_a", 64'({bus_a.in_ready_o, bus_a.out_valid_o, bus_a.out_last_o,
                                  busy_a, done_a, bus_a.out_data_o}), 64'd0);
    check("reset_outputs_b", 64'({bus_b.in_ready_o, bus_b.out_valid_o, bus_b.out_last_o,
                                  busy_b, done_b, bus_b.out_data_o}), 64'd0);
    #20;
    rst_n = 1'b1;

    run_b(0);
    run_b(1);

    run_frame(0, 0, 0, 0, 0, 0);
    check("lit_bin5", 64'(got_word[5]), 64'h0500_0300);
    check("lit_bin4", 64'(got_word[4]), 64'h0400_0000);
    check("lit_bin255", 64'(got_word[255]), 64'hff00_0000);

    run_frame(0, 1, 0, 0, 0, 0);
    check("lit_ramp_bin100", 64'(got_word[100]), 64'h6400_0003);

    run_frame(1, 1, 0, 0, 0, 0);
    check("lit_cdf_bin0", 64'(got_word[0]), 64'h0000_0003);
    check("lit_cdf_bin9", 64'(got_word[9]), 64'h0900_001e);
    check("lit_cdf_bin255", 64'(got_word[255]), 64'hff00_0300);

    run_frame(0, 2, 30, 0, 0, 0);
    run_frame(0, 2, 0, 0, 0, 0);
    run_frame(1, 3, 25, 50, 0, 0);
    run_frame(0, 3, 0, 40, 0, 0);

    run_frame(1, 3, 20, 0, 100, 0);
    check("idle_after_abort", 64'({busy_a, done_a}), 64'd0);
    run_frame(0, 3, 10, 30, 0, 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
